// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: writeback, issue and read-port signals.
// Decode/writeback stages drive the master side; the register file is the slave.
interface regfile_sb_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              issue_en;
  logic [AW-1:0]     issue_rd;
  logic              issue_ok;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              sb_err;

  modport master (
    output we, waddr, wdata, issue_en, issue_rd, raddr,
    input  issue_ok, rdata, rbusy, sb_err
  );

  modport slave (
    input  we, waddr, wdata, issue_en, issue_rd, raddr,
    output issue_ok, rdata, rbusy, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy-bit scoreboard.
// NRD combinational read ports, one writeback port, issue-time busy marking,
// WAW detection via issue_ok and a sticky protocol-error flag.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writeback
// data (and busy state) onto matching read ports.
module regfile_sb #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
) (
  input logic         clk,
  input logic         rstn,
  regfile_sb_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);

  logic [DW-1:0]     regs_q [NREG];
  logic [DW-1:0]     regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              sb_err_q;
  logic              sb_err_d;
  logic              wb_en;
  logic              issue_ok;
  logic              issue_fire;
  logic [NRD*DW-1:0] rdata_all;
  logic [NRD-1:0]    rbusy_all;

  // Writes to r0 are dropped entirely (no data, no busy clear, no error).
  assign wb_en = bus.we && (bus.waddr != '0);

  // WAW check: a busy destination may only be re-issued when it retires this cycle.
  always_comb begin
    issue_ok = !bus.issue_en || (bus.issue_rd == '0) || !busy_q[bus.issue_rd] ||
               (bus.we && (bus.waddr == bus.issue_rd));
  end

  assign issue_fire = bus.issue_en && issue_ok && (bus.issue_rd != '0);

  // Next-state: writeback first, then issue so a same-edge issue wins over the clear.
  always_comb begin
    regs_d   = regs_q;
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    if (wb_en) begin
      regs_d[bus.waddr] = bus.wdata;
      busy_d[bus.waddr] = 1'b0;
      if (!busy_q[bus.waddr]) sb_err_d = 1'b1;
    end
    if (issue_fire) busy_d[bus.issue_rd] = 1'b1;
    if (bus.issue_en && !issue_ok) sb_err_d = 1'b1;
  end

  // State registers; asynchronous reset clears data, busy bits and the error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zero;
    assign ra   = bus.raddr[k*AW +: AW];
    assign zero = (ra == '0);
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wb_en && (ra == bus.waddr);
    assign rdata_all[k*DW +: DW] = zero ? '0 : (hit ? bus.wdata : regs_q[ra]);
    // Forwarded busy reflects the post-edge value: set only if re-issued this cycle.
    assign rbusy_all[k] = zero ? 1'b0 :
                          (hit ? (issue_fire && (bus.issue_rd == bus.waddr)) : busy_q[ra]);
`else
    assign rdata_all[k*DW +: DW] = zero ? '0 : regs_q[ra];
    assign rbusy_all[k]          = zero ? 1'b0 : busy_q[ra];
`endif
  end

  assign bus.issue_ok = issue_ok;
  assign bus.rdata    = rdata_all;
  assign bus.rbusy    = rbusy_all;
  assign bus.sb_err   = sb_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then randomized traffic,
// all compared against an array-based reference model of the register file rules.
module tb_regfile_sb;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned AW   = 5;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  regfile_sb_if #(.DW(DW), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_sb #(.DW(DW), .NREG(NREG), .NRD(NRD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mregs [NREG];
  bit            mbusy [NREG];
  bit            merr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
    merr = 1'b0;
  endtask

  function automatic bit model_ok();
    int ird;
    ird = int'(bus.issue_rd);
    return !bus.issue_en || ird == 0 || !mbusy[ird] || (bus.we && bus.waddr == bus.issue_rd);
  endfunction

  // Compare all outputs against the model for the inputs currently applied.
  task automatic check_outputs(input string tag);
    bit ok;
    bit wb;
    ok = model_ok();
    wb = bus.we && bus.waddr != 0;
    chk({tag, ".issue_ok"}, {31'd0, bus.issue_ok}, {31'd0, ok});
    chk({tag, ".sb_err"}, {31'd0, bus.sb_err}, {31'd0, merr});
    for (int k = 0; k < NRD; k++) begin
      int a;
      logic [DW-1:0] ed;
      bit eb;
      a  = int'(bus.raddr[k*AW +: AW]);
      ed = mregs[a];
      eb = mbusy[a];
`ifdef REGFILE_BYPASS_EN
      if (wb && a == int'(bus.waddr)) begin
        ed = bus.wdata;
        eb = bus.issue_en && ok && bus.issue_rd == bus.waddr;
      end
`endif
      if (a == 0) begin
        ed = '0;
        eb = 1'b0;
      end
      chk($sformatf("%s.rdata%0d", tag, k), bus.rdata[k*DW +: DW], ed);
      chk($sformatf("%s.rbusy%0d", tag, k), {31'd0, bus.rbusy[k]}, {31'd0, eb});
    end
  endtask

  task automatic setin(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit ie, input int ird, input int ra0, input int ra1);
    bus.we       = we;
    bus.waddr    = AW'(wa);
    bus.wdata    = wd;
    bus.issue_en = ie;
    bus.issue_rd = AW'(ird);
    bus.raddr    = {AW'(ra1), AW'(ra0)};
  endtask

  // Check current cycle, clock the DUT, advance the model with the same inputs.
  task automatic tick(input string tag);
    bit ok;
    #2;
    check_outputs(tag);
    ok = model_ok();
    @(posedge clk);
    if (bus.we && bus.waddr != 0) begin
      if (!mbusy[bus.waddr]) merr = 1'b1;
      mregs[bus.waddr] = bus.wdata;
      mbusy[bus.waddr] = 1'b0;
    end
    if (bus.issue_en && ok && bus.issue_rd != 0) mbusy[bus.issue_rd] = 1'b1;
    if (bus.issue_en && !ok) merr = 1'b1;
    #1;
  endtask

  task automatic step(input string tag, input bit we, input int wa, input logic [DW-1:0] wd,
                      input bit ie, input int ird, input int ra0, input int ra1);
    setin(we, wa, wd, ie, ird, ra0, ra1);
    tick(tag);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    setin(1'b0, 0, '0, 1'b0, 0, 5, 31);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    chk({tag, ".zero_rdata"}, bus.rdata[DW-1:0] | bus.rdata[2*DW-1:DW], '0);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    model_reset();
    setin(1'b0, 0, '0, 1'b0, 0, 0, 0);
    #2;
    do_reset("por");

    // Basic write/read: issue first so writebacks are legal.
    step("iss5", 1'b0, 0, '0, 1'b1, 5, 5, 5);
    step("iss31", 1'b0, 0, '0, 1'b1, 31, 5, 31);
    step("wb5", 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 31);
    step("wb31", 1'b1, 31, 32'h12345678, 1'b0, 0, 5, 5);
    setin(1'b0, 0, '0, 1'b0, 0, 5, 31);
    #2;
    chk("r5_p0", bus.rdata[DW-1:0], 32'hDEADBEEF);
    chk("r31_p1", bus.rdata[2*DW-1:DW], 32'h12345678);
    tick("rd_5_31");
    step("rd_31_5", 1'b0, 0, '0, 1'b0, 0, 31, 5);
    step("wb0", 1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 0, 0);
    setin(1'b0, 0, '0, 1'b0, 0, 0, 0);
    #2;
    chk("r0_zero", bus.rdata[DW-1:0], '0);
    chk("r0_no_err", {31'd0, bus.sb_err}, 32'd0);
    tick("rd0");

    // Scoreboard on r7
    step("iss7", 1'b0, 0, '0, 1'b1, 7, 7, 7);
    setin(1'b1, 7, 32'hA5, 1'b0, 0, 7, 7);
    #2;
    chk("r7_busy", {31'd0, bus.rbusy[0]}, 32'd1);
    tick("wb7");
    step("rd7", 1'b0, 0, '0, 1'b0, 0, 7, 7);
    step("iss7b", 1'b0, 0, '0, 1'b1, 7, 7, 0);
    setin(1'b0, 0, '0, 1'b1, 7, 7, 7);
    #2;
    chk("waw_ok", {31'd0, bus.issue_ok}, 32'd0);
    tick("waw");
    setin(1'b0, 0, '0, 1'b0, 0, 7, 7);
    #2;
    chk("waw_err", {31'd0, bus.sb_err}, 32'd1);
    chk("waw_busy", {31'd0, bus.rbusy[1]}, 32'd1);
    tick("after_waw");

    do_reset("mid_rst");

    // Same-edge writeback and issue to r9 (r9 busy first so the writeback is legal)
    step("iss9", 1'b0, 0, '0, 1'b1, 9, 9, 0);
    setin(1'b1, 9, 32'h55, 1'b1, 9, 9, 1);
    #2;
    chk("sim_ok", {31'd0, bus.issue_ok}, 32'd1);
    tick("sim9");
    setin(1'b0, 0, '0, 1'b0, 0, 9, 9);
    #2;
    chk("sim_data", bus.rdata[DW-1:0], 32'h55);
    chk("sim_busy", {31'd0, bus.rbusy[0]}, 32'd1);
    tick("rd9");

    // Bypass behaviour on r3
    step("iss3", 1'b0, 0, '0, 1'b1, 3, 3, 3);
    setin(1'b1, 3, 32'h77, 1'b0, 0, 3, 3);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", bus.rdata[DW-1:0], 32'h77);
    chk("byp_busy", {31'd0, bus.rbusy[0]}, 32'd0);
`else
    chk("nobyp_old", bus.rdata[DW-1:0], 32'h0);
    chk("nobyp_busy", {31'd0, bus.rbusy[0]}, 32'd1);
`endif
    tick("wb3");
    setin(1'b0, 0, '0, 1'b0, 0, 3, 3);
    #2;
    chk("r3_next", bus.rdata[2*DW-1:DW], 32'h77);
    tick("rd3");

    // Protocol error: writeback to a non-busy r4
    setin(1'b0, 0, '0, 1'b0, 0, 4, 4);
    #2;
    chk("pre_err", {31'd0, bus.sb_err}, 32'd0);
    tick("pre4");
    step("wb4", 1'b1, 4, 32'hCAFE0004, 1'b0, 0, 4, 0);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 0, '0, 1'b0, 0, 4, 4);
    setin(1'b0, 0, '0, 1'b0, 0, 4, 4);
    #2;
    chk("err_sticky", {31'd0, bus.sb_err}, 32'd1);
    chk("r4_data", bus.rdata[DW-1:0], 32'hCAFE0004);
    tick("rd4");

    // Randomized traffic in two epochs, addresses biased to a few registers
    for (int e = 0; e < 2; e++) begin
      do_reset("rnd_rst");
      for (int i = 0; i < 300; i++) begin
        step("rnd",
             ($urandom_range(0, 99) < 50), int'($urandom_range(0, 7)), $urandom(),
             ($urandom_range(0, 99) < (e == 0 ? 30 : 60)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 9)), int'($urandom_range(0, 7)));
      end
    end
    do_reset("final_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: never let the run hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
